// File: rtl/sha256_msg_sched_pkg.sv
// Shared types and constants for the SHA-256 message schedule and round engine.
// The K table is indexed downstream by the schedule's round index.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int SCHED_WIN      = 16;
    localparam int ROUNDS_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t k_of(input logic [5:0] idx);
        return K[idx];
    endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// Load and word-stream handshake between the block source, the schedule and the round engine.
interface sha256_msg_sched_if
    import sha256_pkg::*;
#(
    parameter int IDX_W = 6
);

    logic             flush;
    logic             start;
    logic             start_ready;
    logic [511:0]     block_in;
    logic             w_valid;
    logic             w_ready;
    word_t            w_data;
    logic [IDX_W-1:0] w_idx;
    logic             done;

    modport master (
        output flush, start, block_in, w_ready,
        input  start_ready, w_valid, w_data, w_idx, done
    );

    modport slave (
        input  flush, start, block_in, w_ready,
        output start_ready, w_valid, w_data, w_idx, done
    );

endinterface

// File: rtl/sha256_msg_sched_small_sigma.sv
// SHA-256 small sigma: two rotates and a zero-fill shift XORed together; pure wiring plus XOR.
module sha256_small_sigma
    import sha256_pkg::*;
#(
    parameter int R1 = 7,
    parameter int R2 = 18,
    parameter int S  = 3
) (
    input  word_t x_i,
    output word_t y_o
);

    word_t rot1;
    word_t rot2;
    word_t shr;

    assign rot1 = (x_i >> R1) | (x_i << (32 - R1));
    assign rot2 = (x_i >> R2) | (x_i << (32 - R2));
    assign shr  = x_i >> S;
    assign y_o  = rot1 ^ rot2 ^ shr;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads a 512-bit block into a 16-word window and streams
// W[0..ROUNDS-1] with valid/ready, expanding the window by one word per accepted beat.
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEFAULT,
    parameter int IDX_W  = 6
) (
    input logic               clk,
    input logic               rst_n,
    sha256_msg_sched_if.slave bus
);

    state_t           state_q;
    word_t            window_q [SCHED_WIN];
    logic [IDX_W-1:0] t_q;
    logic             start_ready_q;
    logic             w_valid_q;
    logic             done_q;

    word_t            blk_word_d [SCHED_WIN];
    word_t            win_shift_d [SCHED_WIN];
    word_t            sig0;
    word_t            sig1;
    word_t            w_new_d;
    logic             beat;
    logic             last;

    genvar gi;

    // Word 0 of the window sits in the top bits of the block.
    generate
        for (gi = 0; gi < SCHED_WIN; gi++) begin : g_unpack
            assign blk_word_d[gi] = bus.block_in[511 - 32*gi -: 32];
        end
    endgenerate

    sha256_small_sigma #(.R1(7),  .R2(18), .S(3))  u_sigma0 (
        .x_i (window_q[1]),
        .y_o (sig0)
    );

    sha256_small_sigma #(.R1(17), .R2(19), .S(10)) u_sigma1 (
        .x_i (window_q[14]),
        .y_o (sig1)
    );

    assign w_new_d = sig1 + window_q[9] + sig0 + window_q[0];

    generate
        for (gi = 0; gi < SCHED_WIN - 1; gi++) begin : g_shift
            assign win_shift_d[gi] = window_q[gi + 1];
        end
    endgenerate
    assign win_shift_d[SCHED_WIN - 1] = w_new_d;

    assign beat = w_valid_q & bus.w_ready;
    assign last = (t_q == IDX_W'(ROUNDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            t_q           <= '0;
            start_ready_q <= 1'b1;
            w_valid_q     <= 1'b0;
            done_q        <= 1'b0;
            for (int i = 0; i < SCHED_WIN; i++) begin
                window_q[i] <= '0;
            end
        end else if (bus.flush) begin
            state_q       <= IDLE;
            t_q           <= '0;
            start_ready_q <= 1'b1;
            w_valid_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        window_q      <= blk_word_d;
                        t_q           <= '0;
                        state_q       <= RUN;
                        start_ready_q <= 1'b0;
                        w_valid_q     <= 1'b1;
                    end
                end
                RUN: begin
                    // The last word leaves the window untouched; its expansion is never used.
                    if (beat) begin
                        if (last) begin
                            state_q   <= DONE;
                            w_valid_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            window_q <= win_shift_d;
                            t_q      <= t_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q       <= IDLE;
                    t_q           <= '0;
                    done_q        <= 1'b0;
                    start_ready_q <= 1'b1;
                end
                default: begin
                    state_q       <= IDLE;
                    t_q           <= '0;
                    start_ready_q <= 1'b1;
                    w_valid_q     <= 1'b0;
                    done_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.w_valid     = w_valid_q;
    assign bus.w_data      = window_q[0];
    assign bus.w_idx       = t_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for the SHA-256 message schedule: reference schedule model, hand-computed
// checkpoint table, and directed sequences for backpressure, abort and reset.
module tb_sha256_msg_sched;
    import sha256_pkg::*;

    localparam int IDX_W = 6;

    logic clk;
    logic rst_n;

    sha256_msg_sched_if #(.IDX_W(IDX_W)) bus ();

    sha256_msg_sched #(.ROUNDS(64), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] got [64];

    typedef struct {
        int          sel;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_FF  = {512{1'b1}};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic void model(input logic [511:0] blk, output logic [31:0] w [64]);
        logic [31:0] s0;
        logic [31:0] s1;
        for (int t = 0; t < 16; t++) begin
            w[t] = blk[511 - 32*t -: 32];
        end
        for (int t = 16; t < 64; t++) begin
            s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
    endfunction

    task automatic apply_table(input int sel);
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].sel == sel) begin
                chk($sformatf("vec_w%0d", vecs[i].idx), got[vecs[i].idx], vecs[i].exp);
            end
        end
    endtask

    task automatic start_block(input logic [511:0] blk);
        int n = 0;
        while (!bus.start_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("start_ready", bus.start_ready, 1);
        bus.block_in = blk;
        bus.start    = 1'b1;
        bus.w_ready  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("first_valid", bus.w_valid, 1);
        chk("first_idx", bus.w_idx, 0);
    endtask

    // Streams words from the current cycle; stop_at < 64 leaves the block mid-run.
    task automatic stream(input logic [511:0] blk, input bit rnd, input int stop_at, input bit poke_start);
        logic [31:0]      exp_w [64];
        int               beats = 0;
        int               cycles = 0;
        bit               stalled = 0;
        logic [31:0]      prev_d = '0;
        logic [IDX_W-1:0] prev_i = '0;
        model(blk, exp_w);
        while (beats < stop_at && cycles < 2000) begin
            chk("w_valid_hold", bus.w_valid, 1);
            if (!bus.w_valid) break;
            chk("done_early", bus.done, 0);
            if (stalled) begin
                chk("stall_data", bus.w_data, prev_d);
                chk("stall_idx", bus.w_idx, prev_i);
            end
            if (poke_start && beats == 10) begin
                chk("start_ready_run", bus.start_ready, 0);
                bus.start    = 1'b1;
                bus.block_in = BLK_FF;
            end
            bus.w_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (bus.w_ready) begin
                chk("w_idx", bus.w_idx, beats);
                chk($sformatf("w_data%0d", beats), bus.w_data, exp_w[beats]);
                got[beats] = bus.w_data;
                beats++;
                stalled = 0;
            end else begin
                stalled = 1;
                prev_d  = bus.w_data;
                prev_i  = bus.w_idx;
            end
            @(negedge clk);
            cycles++;
            bus.start = 1'b0;
        end
        chk("beat_count", beats, stop_at);
        if (stop_at == 64) begin
            bus.w_ready = 1'b0;
            chk("done_pulse", bus.done, 1);
            chk("valid_after_last", bus.w_valid, 0);
            @(negedge clk);
            chk("done_clear", bus.done, 0);
            chk("start_ready_idle", bus.start_ready, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 0,  32'h61626380};
        vecs[1] = '{0, 1,  32'h00000000};
        vecs[2] = '{0, 14, 32'h00000000};
        vecs[3] = '{0, 15, 32'h00000018};
        vecs[4] = '{0, 16, 32'h61626380};
        vecs[5] = '{0, 17, 32'h000F0000};
        vecs[6] = '{1, 0,  32'hFFFFFFFF};
        vecs[7] = '{1, 16, 32'h203FFFFC};
        vecs[8] = '{1, 17, 32'h203FFFFC};

        rst_n        = 1'b0;
        bus.flush    = 1'b0;
        bus.start    = 1'b0;
        bus.block_in = '0;
        bus.w_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_start_ready", bus.start_ready, 1);
        chk("rst_w_valid", bus.w_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_w_idx", bus.w_idx, 0);
        chk("rst_w_data", bus.w_data, 0);

        // "abc" with the round engine always ready, then under random backpressure
        start_block(BLK_ABC);
        stream(BLK_ABC, 1'b0, 64, 1'b0);
        apply_table(0);
        $display("block abc ready=1 checks=%0d errors=%0d", checks, errors);

        start_block(BLK_ABC);
        stream(BLK_ABC, 1'b1, 64, 1'b0);
        apply_table(0);
        $display("block abc ready=random checks=%0d errors=%0d", checks, errors);

        start_block(BLK_FF);
        stream(BLK_FF, 1'b1, 64, 1'b0);
        apply_table(1);
        $display("block all-ones checks=%0d errors=%0d", checks, errors);

        // start during RUN must not disturb the running block
        start_block(BLK_ABC);
        stream(BLK_ABC, 1'b0, 64, 1'b1);
        apply_table(0);
        $display("start during run checks=%0d errors=%0d", checks, errors);

        // flush together with start at t=30
        start_block(BLK_ABC);
        stream(BLK_ABC, 1'b1, 30, 1'b0);
        chk("flush_at_idx", bus.w_idx, 30);
        bus.flush    = 1'b1;
        bus.start    = 1'b1;
        bus.block_in = BLK_FF;
        bus.w_ready  = 1'b1;
        @(negedge clk);
        bus.flush   = 1'b0;
        bus.start   = 1'b0;
        bus.w_ready = 1'b0;
        chk("flush_valid", bus.w_valid, 0);
        chk("flush_start_ready", bus.start_ready, 1);
        chk("flush_idx", bus.w_idx, 0);
        for (int i = 0; i < 3; i++) begin
            chk("flush_no_done", bus.done, 0);
            chk("flush_idle_valid", bus.w_valid, 0);
            @(negedge clk);
        end
        start_block(BLK_ABC);
        stream(BLK_ABC, 1'b0, 64, 1'b0);
        apply_table(0);
        $display("flush with start checks=%0d errors=%0d", checks, errors);

        // asynchronous reset mid-cycle at t=40
        start_block(BLK_ABC);
        stream(BLK_ABC, 1'b0, 40, 1'b0);
        chk("rst_at_idx", bus.w_idx, 40);
        bus.w_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.w_valid, 0);
        chk("async_rst_idx", bus.w_idx, 0);
        chk("async_rst_done", bus.done, 0);
        @(negedge clk);
        bus.w_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_start_ready", bus.start_ready, 1);
        for (int i = 0; i < 2; i++) begin
            chk("post_rst_valid", bus.w_valid, 0);
            chk("post_rst_done", bus.done, 0);
            @(negedge clk);
        end
        start_block(BLK_FF);
        stream(BLK_FF, 1'b1, 64, 1'b0);
        apply_table(1);
        $display("reset mid-run checks=%0d errors=%0d", checks, errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
Sequencer for the SHA-256 message schedule in the miner hash core. Accepts one 512-bit padded block, then streams W[0..ROUNDS-1] to the round engine one word per accepted beat, with valid/ready backpressure. Internally it drives the fixed-rotate networks (ROTR7/18 with SHR3 for sigma0, ROTR17/19 with SHR10 for sigma1) over a 16-word sliding window. It also provides the round index for K-constant lookup.

Parameters:
ROUNDS, 64, number of W words emitted per block (legal range 16..64)
IDX_W, 6, width of round index output (ceil(log2(ROUNDS)))

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort; returns block to IDLE
start  in  1  block load request; accepted only when start_ready=1
start_ready  out  1  high in IDLE
block_in  in  512  padded message block; W[0] = block_in[511:480], W[15] = block_in[31:0]
w_valid  out  1  w_data/w_idx hold a valid schedule word
w_ready  in  1  round engine accepts the word
w_data  out  32  W[t]
w_idx  out  IDX_W  t, round index for K lookup
done  out  1  one-cycle pulse after W[ROUNDS-1] is accepted

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-low (rst_n); all other state changes on rising clk.
- Reset values: state=IDLE; start_ready=1 once rst_n deasserts; w_valid=0; done=0; w_idx=0; window words and w_data=0.
- States: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start=1, load window[i] = block_in[511-32i -: 32] for i=0..15. Set t=0 and go to RUN next cycle.
- Latency: the first w_valid is asserted on the cycle after the start accept.
- RUN: w_valid=1, w_data=window[0], w_idx=t.
  - On a beat (w_valid & w_ready), shift the window down by one word.
  - window[15] <= sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], modulo 2^32 (carries discarded).
  - t increments on each beat.
- sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x). sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x). Rotates are pure rewiring; shifts zero-fill.
- Backpressure: if w_ready=0, w_data, w_idx and the window hold exactly. w_valid is never dropped once raised until the beat completes.
- Final beat: the beat with t=ROUNDS-1 moves to DONE. The window update on this beat is don't-care.
- DONE: done=1 and w_valid=0 for exactly one cycle, then return to IDLE.
- start while not IDLE: ignored; start_ready=0.
- flush=1 in any state: next state IDLE, w_valid=0, no done pulse, t=0.
- flush and start in the same cycle: flush wins and the block is not loaded.
- rst_n asserted mid-RUN: immediate return to reset values. No done pulse and no partial output after release.
- Back-to-back blocks: a new start is accepted on the cycle after DONE (IDLE), so the minimum inter-block gap is 2 cycles.

Decomposition:
- Package sha256_pkg holds:
  - word_t (32-bit)
  - SCHED_WIN = 16
  - ROUNDS_DEFAULT = 64
  - state enum {IDLE, RUN, DONE}
  - the K[0..63] constant table, used downstream with w_idx
- One natural combinational sub-module: sha256_small_sigma, with parameters R1, R2, S (rotate, rotate, shift amounts). It is instantiated twice: (7,18,3) for sigma0 and (17,19,10) for sigma1.
- Window, counter and FSM live in the top module.

Test Plan:
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready tied 1:
  - 64 consecutive beats with w_idx 0..63.
  - W16=0x61626380, W17=0x000F0000.
  - All 64 words match the FIPS 180-4 "abc" schedule.
  - done pulses once on the cycle after beat 63.
- Same block with w_ready toggled pseudo-randomly (about 50%): word sequence identical to the previous case; w_data/w_idx stable while w_valid=1 & w_ready=0.
- Block of all 0xFFFFFFFF words: checks modulo-2^32 wrap of the 4-term sum against a software model for all 64 words.
- start pulsed during RUN at t=10: ignored; sequence continues unchanged with the original block.
- flush asserted at t=30 together with start: returns to IDLE with no done pulse; the following start runs "abc" from w_idx=0 correctly.
- rst_n dropped asynchronously mid-cycle at t=40: w_valid falls immediately; after release start_ready=1 and a fresh block streams correctly.
